// File: rtl/cache_line_fill.sv
// Cache line refill assembler: critical-word-first wrap-around fill from a
// valid/ready memory stream, plus single-word store hits while idle.
module cache_line_fill #(
    parameter int WORD_W = 32,
    parameter int NWORDS = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     fill_start,
    input  logic [2:0]               fill_sel,
    input  logic                     mem_valid,
    input  logic [WORD_W-1:0]        mem_data,
    output logic                     mem_ready,
    input  logic                     wr_en,
    input  logic [2:0]               wr_sel,
    input  logic [WORD_W-1:0]        wr_data,
    output logic                     wr_accept,
    output logic [NWORDS*WORD_W-1:0] line_out,
    output logic [NWORDS-1:0]        word_valid,
    output logic                     crit_valid,
    output logic [WORD_W-1:0]        crit_data,
    output logic                     busy,
    output logic                     fill_done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [2:0]          idx_q, idx_d;
    logic [2:0]          cnt_q, cnt_d;
    logic [WORD_W-1:0]   line_q [NWORDS];
    logic [WORD_W-1:0]   line_d [NWORDS];
    logic [NWORDS-1:0]   wv_q, wv_d;
    logic                crit_valid_q, crit_valid_d;
    logic [WORD_W-1:0]   crit_data_q, crit_data_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            cnt_q        <= '0;
            wv_q         <= '0;
            crit_valid_q <= 1'b0;
            crit_data_q  <= '0;
            for (int k = 0; k < NWORDS; k++) begin
                line_q[k] <= '0;
            end
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            cnt_q        <= cnt_d;
            wv_q         <= wv_d;
            crit_valid_q <= crit_valid_d;
            crit_data_q  <= crit_data_d;
            for (int k = 0; k < NWORDS; k++) begin
                line_q[k] <= line_d[k];
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        cnt_d        = cnt_q;
        wv_d         = wv_q;
        crit_valid_d = 1'b0;
        crit_data_d  = crit_data_q;
        for (int k = 0; k < NWORDS; k++) begin
            line_d[k] = line_q[k];
        end

        unique case (state_q)
            IDLE: begin
                // A refill request takes priority over a coincident store.
                if (fill_start) begin
                    state_d = FILL;
                    idx_d   = fill_sel;
                    cnt_d   = 3'd0;
                    wv_d    = '0;
                end else if (wr_en) begin
                    line_d[wr_sel] = wr_data;
                    wv_d[wr_sel]   = 1'b1;
                end
            end
            FILL: begin
                if (mem_valid) begin
                    line_d[idx_q] = mem_data;
                    wv_d[idx_q]   = 1'b1;
                    idx_d         = idx_q + 3'd1;
                    cnt_d         = cnt_q + 3'd1;
                    if (cnt_q == 3'd0) begin
                        crit_valid_d = 1'b1;
                        crit_data_d  = mem_data;
                    end
                    if (cnt_q == 3'd7) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy       = (state_q != IDLE);
    assign mem_ready  = (state_q == FILL);
    assign fill_done  = (state_q == DONE);
    assign wr_accept  = (state_q == IDLE) & ~fill_start;
    assign word_valid = wv_q;
    assign crit_valid = crit_valid_q;
    assign crit_data  = crit_data_q;

    for (genvar k = 0; k < NWORDS; k++) begin : g_line
        assign line_out[k*WORD_W +: WORD_W] = line_q[k];
    end

endmodule

// File: tb/tb_cache_line_fill.sv
// Scoreboard bench for cache_line_fill: directed refills, stores, reset abort.
module tb_cache_line_fill;

    localparam int W  = 32;
    localparam int NW = 8;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            fill_start = 1'b0;
    logic [2:0]      fill_sel = '0;
    logic            mem_valid = 1'b0;
    logic [W-1:0]    mem_data = '0;
    logic            mem_ready;
    logic            wr_en = 1'b0;
    logic [2:0]      wr_sel = '0;
    logic [W-1:0]    wr_data = '0;
    logic            wr_accept;
    logic [NW*W-1:0] line_out;
    logic [NW-1:0]   word_valid;
    logic            crit_valid;
    logic [W-1:0]    crit_data;
    logic            busy;
    logic            fill_done;

    cache_line_fill #(.WORD_W(W), .NWORDS(NW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .fill_start (fill_start),
        .fill_sel   (fill_sel),
        .mem_valid  (mem_valid),
        .mem_data   (mem_data),
        .mem_ready  (mem_ready),
        .wr_en      (wr_en),
        .wr_sel     (wr_sel),
        .wr_data    (wr_data),
        .wr_accept  (wr_accept),
        .line_out   (line_out),
        .word_valid (word_valid),
        .crit_valid (crit_valid),
        .crit_data  (crit_data),
        .busy       (busy),
        .fill_done  (fill_done)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state
    logic [W-1:0]  m_line [NW];
    logic [NW-1:0] m_wv;
    logic [2:0]    m_idx;
    int            m_cnt;

    // Scoreboard queues: expected critical words and expected completed lines
    logic [W-1:0]    crit_q [$];
    logic [NW*W-1:0] done_line_q [$];
    logic [NW-1:0]   done_wv_q [$];

    task automatic chk(input string name, input logic [NW*W-1:0] act, input logic [NW*W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [NW*W-1:0] pack_model();
        logic [NW*W-1:0] p;
        for (int k = 0; k < NW; k++) p[k*W +: W] = m_line[k];
        return p;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < NW; k++) m_line[k] = '0;
        m_wv  = '0;
        m_idx = '0;
        m_cnt = 0;
    endtask

    task automatic check_model(input string tag);
        chk({tag, " line_out"}, line_out, pack_model());
        chk({tag, " word_valid"}, {{(NW*W-NW){1'b0}}, word_valid}, {{(NW*W-NW){1'b0}}, m_wv});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: pops expectations whenever the DUT presents a pulse
    always @(negedge clk) begin
        if (rst_n) begin
            if (crit_valid) begin
                if (crit_q.size() == 0) begin
                    n_cmp++; n_err++;
                    $display("FAIL crit_unexpected: got crit_data %h with nothing expected", crit_data);
                end else begin
                    chk("crit_data", {{(NW*W-W){1'b0}}, crit_data}, {{(NW*W-W){1'b0}}, crit_q.pop_front()});
                end
            end
            if (fill_done) begin
                if (done_line_q.size() == 0) begin
                    n_cmp++; n_err++;
                    $display("FAIL done_unexpected: got fill_done=1 expected 0");
                end else begin
                    chk("done line_out", line_out, done_line_q.pop_front());
                    chk("done word_valid", {{(NW*W-NW){1'b0}}, word_valid}, {{(NW*W-NW){1'b0}}, done_wv_q.pop_front()});
                end
            end
        end
    end

    task automatic start_fill(input logic [2:0] sel);
        fill_start = 1'b1;
        fill_sel   = sel;
        tick();
        fill_start = 1'b0;
        m_idx = sel;
        m_cnt = 0;
        m_wv  = '0;
        chk("busy at fill", {255'b0, busy}, 256'd1);
        chk("mem_ready at fill", {255'b0, mem_ready}, 256'd1);
    endtask

    task automatic beat(input logic [W-1:0] d);
        mem_valid = 1'b1;
        mem_data  = d;
        if (m_cnt == 0) crit_q.push_back(d);
        tick();
        mem_valid = 1'b0;
        mem_data  = 32'hBAD0_BAD0;
        m_line[m_idx] = d;
        m_wv[m_idx]   = 1'b1;
        m_idx = m_idx + 3'd1;
        m_cnt++;
        check_model("beat");
        if (m_cnt == 8) begin
            done_line_q.push_back(pack_model());
            done_wv_q.push_back(m_wv);
            chk("fill_done after 8th beat", {255'b0, fill_done}, 256'd1);
            tick();
            chk("fill_done one cycle", {255'b0, fill_done}, 256'd0);
            chk("busy after done", {255'b0, busy}, 256'd0);
        end
    endtask

    task automatic stall_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            chk("busy during stall", {255'b0, busy}, 256'd1);
            check_model("stall");
        end
    endtask

    initial begin
        model_reset();
        #2;
        chk("reset line_out", line_out, '0);
        chk("reset ctrl", {249'b0, word_valid[6:0] == 0, busy, mem_ready, crit_valid, fill_done, word_valid[7], 1'b0},
            {249'b0, 1'b1, 6'b0});
        chk("reset crit_data", {224'b0, crit_data}, 256'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // Refill from slot 0, consecutive beats
        start_fill(3'd0);
        for (int i = 0; i < 8; i++) beat(32'hA0 + i);
        chk("fill0 slot7", {224'b0, line_out[7*W +: W]}, 256'hA7);

        // Back-to-back wrap-around refill from slot 5
        start_fill(3'd5);
        for (int i = 0; i < 8; i++) beat(32'hB0 + i);
        chk("fill5 slot0", {224'b0, line_out[0 +: W]}, 256'hB3);
        chk("fill5 slot5", {224'b0, line_out[5*W +: W]}, 256'hB0);

        // Refill from slot 2 with mem_valid pattern 1,0,0,1,...
        tick();
        start_fill(3'd2);
        for (int i = 0; i < 8; i++) begin
            beat(32'hC0 + i);
            if (i < 7) stall_cycles(2);
        end

        // IDLE store
        wr_en = 1'b1; wr_sel = 3'd3; wr_data = 32'hDEAD;
        #1;
        chk("wr_accept idle", {255'b0, wr_accept}, 256'd1);
        tick();
        wr_en = 1'b0;
        m_line[3] = 32'hDEAD;
        m_wv[3]   = 1'b1;
        check_model("store");

        // Store coincident with fill_start loses
        wr_en = 1'b1; wr_sel = 3'd3; wr_data = 32'h1234; fill_start = 1'b1; fill_sel = 3'd4;
        #1;
        chk("wr_accept with start", {255'b0, wr_accept}, 256'd0);
        start_fill(3'd4);
        check_model("after start+store");
        chk("wr_accept in fill", {255'b0, wr_accept}, 256'd0);
        beat(32'hD0);
        beat(32'hD1);
        wr_en = 1'b0;
        // Re-pulsed fill_start during FILL is ignored
        fill_start = 1'b1; fill_sel = 3'd0;
        tick();
        fill_start = 1'b0;
        check_model("ignored start");
        for (int i = 2; i < 8; i++) beat(32'hD0 + i);
        chk("restart slot4", {224'b0, line_out[4*W +: W]}, 256'hD0);

        // Asynchronous reset after the 4th beat aborts the refill
        start_fill(3'd1);
        for (int i = 0; i < 4; i++) beat(32'hE0 + i);
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("abort line_out", line_out, '0);
        chk("abort ctrl", {251'b0, word_valid != 0, busy, mem_ready, crit_valid, fill_done}, 256'd0);
        chk("abort crit_data", {224'b0, crit_data}, 256'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        chk("no done after abort", {255'b0, fill_done}, 256'd0);

        start_fill(3'd6);
        for (int i = 0; i < 8; i++) beat(32'hF0 + i);
        tick();
        tick();

        chk("crit queue drained", {224'b0, 32'(crit_q.size())}, 256'd0);
        chk("done queue drained", {224'b0, 32'(done_line_q.size())}, 256'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
